// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch sequencing controller.
package stopwatch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    FULL  = 3'd4
  } sw_state_t;

  typedef logic [3:0] bcd4_t;
  typedef logic [2:0] bcd3_t;

  localparam bcd4_t MAX_SU = 4'd9;
  localparam bcd3_t MAX_ST = 3'd5;
  localparam bcd4_t MAX_MU = 4'd9;
  localparam bcd3_t MAX_MT = 3'd5;

  // True when the live counter shows 59:59 and must not be advanced further.
  function automatic logic at_terminal(bcd4_t su, bcd3_t st, bcd4_t mu, bcd3_t mt);
    return (su == MAX_SU) && (st == MAX_ST) && (mu == MAX_MU) && (mt == MAX_MT);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn.sv
// Raw push-button conditioning: two-flop synchronizer followed by a
// registered rising-edge detector. A held button yields one pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic meta_q, sync_q, prev_q, pulse_q;

  // Synchronize the async level, then flag the 0->1 transition for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= sync_q & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller: button events, 1 Hz count enable,
// counter clear, lap freeze and display source selection.
//
// state | meaning
// IDLE  | stopped, counter may be cleared
// RUN   | counting, display live
// LAP   | counting, display frozen on latched digits
// PAUSE | stopped, prescaler phase held for resume
// FULL  | 59:59 reached, counting inhibited until clear
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  btn_start,
  input  logic  btn_lap,
  input  logic  btn_clear,
  input  bcd4_t sec_units,
  input  bcd3_t sec_tens,
  input  bcd4_t min_units,
  input  bcd3_t min_tens,
  output logic  cnt_en,
  output logic  cnt_clr,
  output bcd4_t disp_su,
  output bcd3_t disp_st,
  output bcd4_t disp_mu,
  output bcd3_t disp_mt,
  output logic  running,
  output logic  lap_active,
  output logic  full
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic start_p, lap_p, clear_p;

  btn_sync_edge u_start (.clk(clk), .reset(reset), .din(btn_start), .pulse(start_p));
  btn_sync_edge u_lap   (.clk(clk), .reset(reset), .din(btn_lap),   .pulse(lap_p));
  btn_sync_edge u_clear (.clk(clk), .reset(reset), .din(btn_clear), .pulse(clear_p));

  // Same-cycle events collapse to the single highest-priority one.
  logic ev_clr, ev_start, ev_lap;
  assign ev_clr   = clear_p;
  assign ev_start = start_p & ~clear_p;
  assign ev_lap   = lap_p & ~clear_p & ~start_p;

  sw_state_t     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          cnt_en_q, cnt_en_d, cnt_clr_q, cnt_clr_d;
  logic          running_q, lap_active_q, full_q, lap_load;
  bcd4_t         lap_su_q, lap_mu_q;
  bcd3_t         lap_st_q, lap_mt_q;

  logic counting, tick, terminal;
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PRESC_LAST);
  assign terminal = tick && at_terminal(sec_units, sec_tens, min_units, min_tens);

  // Next-state, prescaler and pulse decisions; one transition per cycle.
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_en_d  = 1'b0;
    cnt_clr_d = 1'b0;
    lap_load  = 1'b0;
    if (counting) presc_d = tick ? '0 : presc_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (ev_clr) begin
          cnt_clr_d = 1'b1;
          presc_d   = '0;
        end else if (ev_start) begin
          state_d = RUN;
        end
      end
      RUN, LAP: begin
        // Terminal tick is swallowed so the counter never wraps past 59:59.
        if (terminal) begin
          state_d = FULL;
        end else begin
          cnt_en_d = tick;
          if (ev_start) begin
            state_d = PAUSE;
          end else if (ev_lap) begin
            state_d  = (state_q == RUN) ? LAP : RUN;
            lap_load = (state_q == RUN);
          end
        end
      end
      PAUSE, FULL: begin
        if (ev_clr) begin
          cnt_clr_d = 1'b1;
          presc_d   = '0;
          state_d   = IDLE;
        end else if (ev_start && state_q == PAUSE) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, prescaler, lap latch and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      presc_q      <= '0;
      cnt_en_q     <= 1'b0;
      cnt_clr_q    <= 1'b0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      full_q       <= 1'b0;
      lap_su_q     <= '0;
      lap_st_q     <= '0;
      lap_mu_q     <= '0;
      lap_mt_q     <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_en_q     <= cnt_en_d;
      cnt_clr_q    <= cnt_clr_d;
      running_q    <= (state_d == RUN) || (state_d == LAP);
      lap_active_q <= (state_d == LAP);
      full_q       <= (state_d == FULL);
      if (lap_load) begin
        lap_su_q <= sec_units;
        lap_st_q <= sec_tens;
        lap_mu_q <= min_units;
        lap_mt_q <= min_tens;
      end
    end
  end

  assign cnt_en     = cnt_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign full       = full_q;

  assign disp_su = lap_active_q ? lap_su_q : sec_units;
  assign disp_st = lap_active_q ? lap_st_q : sec_tens;
  assign disp_mu = lap_active_q ? lap_mu_q : min_units;
  assign disp_mt = lap_active_q ? lap_mt_q : min_tens;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with TICK_DIV=4 and an external mm:ss BCD counter.
module tb_stopwatch_ctrl;

  localparam int TDIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3, M_FULL = 4;

  logic clk, reset, btn_start, btn_lap, btn_clear;
  logic [3:0] c_su, c_mu, disp_su, disp_mu;
  logic [2:0] c_st, c_mt, disp_st, disp_mt;
  logic cnt_en, cnt_clr, running, lap_active, full;
  logic preload_req;
  int   preload_secs;

  stopwatch_ctrl #(.TICK_DIV(TDIV)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .sec_units(c_su), .sec_tens(c_st), .min_units(c_mu), .min_tens(c_mt),
    .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .disp_su(disp_su), .disp_st(disp_st), .disp_mu(disp_mu), .disp_mt(disp_mt),
    .running(running), .lap_active(lap_active), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External mm:ss BCD digit chain driven by the controller.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_su <= '0; c_st <= '0; c_mu <= '0; c_mt <= '0;
    end else if (preload_req) begin
      c_su <= 4'(preload_secs % 10);
      c_st <= 3'((preload_secs / 10) % 6);
      c_mu <= 4'((preload_secs / 60) % 10);
      c_mt <= 3'(preload_secs / 600);
    end else if (cnt_clr) begin
      c_su <= '0; c_st <= '0; c_mu <= '0; c_mt <= '0;
    end else if (cnt_en) begin
      if (c_su == 4'd9) begin
        c_su <= '0;
        if (c_st == 3'd5) begin
          c_st <= '0;
          if (c_mu == 4'd9) begin
            c_mu <= '0;
            c_mt <= (c_mt == 3'd5) ? 3'd0 : c_mt + 3'd1;
          end else c_mu <= c_mu + 4'd1;
        end else c_st <= c_st + 3'd1;
      end else c_su <= c_su + 4'd1;
    end
  end

  // Reference model: whole seconds, prescaler phase, event latency of three edges.
  int m_state, m_phase, m_secs, m_lap;
  bit e_en, e_clr;
  logic [3:0] h_s, h_l, h_c;
  int errors = 0, checks = 0, en_count = 0;

  function automatic int env_secs();
    return int'(c_mt) * 600 + int'(c_mu) * 60 + int'(c_st) * 10 + int'(c_su);
  endfunction

  function automatic logic [13:0] digits(int s);
    logic [13:0] d;
    d = {3'(s / 600), 4'((s / 60) % 10), 3'((s / 10) % 6), 4'(s % 10)};
    return d;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_phase = 0; m_secs = 0; m_lap = 0;
    e_en = 0; e_clr = 0; h_s = '0; h_l = '0; h_c = '0;
  endtask

  task automatic model_step();
    bit ec, es, el, cnt, tk, n_en, n_clr;
    ec = h_c[2] & ~h_c[3];
    es = h_s[2] & ~h_s[3] & ~ec;
    el = h_l[2] & ~h_l[3] & ~ec & ~es;
    h_c = {h_c[2:0], btn_clear};
    h_s = {h_s[2:0], btn_start};
    h_l = {h_l[2:0], btn_lap};
    cnt = (m_state == M_RUN) || (m_state == M_LAP);
    tk  = cnt && (m_phase == TDIV - 1);
    if (cnt) m_phase = tk ? 0 : m_phase + 1;
    n_en = 0; n_clr = 0;
    case (m_state)
      M_IDLE: if (ec) begin n_clr = 1; m_phase = 0; end
              else if (es) m_state = M_RUN;
      M_RUN, M_LAP: begin
        if (tk && m_secs == 3599) m_state = M_FULL;
        else begin
          n_en = tk;
          if (es) m_state = M_PAUSE;
          else if (el) begin
            if (m_state == M_RUN) begin m_lap = m_secs; m_state = M_LAP; end
            else m_state = M_RUN;
          end
        end
      end
      M_PAUSE: if (ec) begin n_clr = 1; m_phase = 0; m_state = M_IDLE; end
               else if (es) m_state = M_RUN;
      default: if (ec) begin n_clr = 1; m_phase = 0; m_state = M_IDLE; end
    endcase
    if (preload_req) m_secs = preload_secs;
    else if (e_clr) m_secs = 0;
    else if (e_en) m_secs = m_secs + 1;
    e_en = n_en; e_clr = n_clr;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt_en", 32'(cnt_en), 32'(e_en));
    chk("cnt_clr", 32'(cnt_clr), 32'(e_clr));
    chk("running", 32'(running), 32'(m_state == M_RUN || m_state == M_LAP));
    chk("lap_active", 32'(lap_active), 32'(m_state == M_LAP));
    chk("full", 32'(full), 32'(m_state == M_FULL));
    chk("disp", 32'({disp_mt, disp_mu, disp_st, disp_su}),
        32'(digits(m_state == M_LAP ? m_lap : m_secs)));
    chk("counter", 32'(env_secs()), 32'(m_secs));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
    if (cnt_en) en_count++;
  endtask

  task automatic step(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_secs(int target, int budget);
    int n = 0;
    while (env_secs() != target && n < budget) begin
      cycle();
      n++;
    end
    chk("wait_secs", 32'(env_secs()), 32'(target));
  endtask

  initial begin
    reset = 1'b0; btn_start = 0; btn_lap = 0; btn_clear = 0;
    preload_req = 0; preload_secs = 0;
    model_reset();
    step(3);
    reset = 1'b1;
    step(3);

    // Reset mid-RUN at 00:07: outputs drop at once, nothing counts afterwards.
    btn_start = 1; step(2); btn_start = 0;
    wait_secs(7, 60);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_cnt_en", 32'(cnt_en), 0);
    chk("rst_cnt_clr", 32'(cnt_clr), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_lap", 32'(lap_active), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_disp", 32'({disp_mt, disp_mu, disp_st, disp_su}), 0);
    step(3);
    reset = 1'b1;
    en_count = 0;
    step(20);
    chk("post_rst_no_en", 32'(en_count), 0);

    // Start held for 20 cycles is a single event; ten ticks reach 00:10.
    btn_start = 1; step(20); btn_start = 0;
    wait_secs(10, 60);
    chk("still_running", 32'(running), 1);

    // Lap freezes display while counting continues, second lap releases it.
    btn_lap = 1; step(2); btn_lap = 0;
    step(14);
    chk("lap_on", 32'(lap_active), 1);
    btn_lap = 1; step(2); btn_lap = 0;
    step(6);
    chk("lap_off", 32'(lap_active), 0);

    // Pause holds for 50 cycles, resume continues the prescale phase.
    btn_start = 1; step(3); btn_start = 0;
    step(5);
    en_count = 0;
    step(50);
    chk("pause_no_en", 32'(en_count), 0);
    btn_start = 1; step(3); btn_start = 0;
    step(20);

    // Clear ignored in RUN.
    btn_clear = 1; step(3); btn_clear = 0;
    step(6);
    chk("run_clear_ignored", 32'(running), 1);

    // Start and clear together in PAUSE: clear wins.
    btn_start = 1; step(3); btn_start = 0;
    step(6);
    btn_start = 1; btn_clear = 1;
    step(6);
    btn_start = 0; btn_clear = 0;
    chk("pause_clr_running", 32'(running), 0);
    chk("pause_clr_counter", 32'(env_secs()), 0);
    step(4);

    // Terminal count from 59:58.
    preload_req = 1; preload_secs = 3598;
    step(1);
    preload_req = 0;
    btn_start = 1; step(2); btn_start = 0;
    step(25);
    chk("full_flag", 32'(full), 1);
    chk("full_counter", 32'(env_secs()), 3599);
    en_count = 0;
    step(12);
    chk("full_no_en", 32'(en_count), 0);
    btn_clear = 1; step(2); btn_clear = 0;
    step(6);
    chk("full_cleared", 32'(env_secs()), 0);
    chk("full_idle", 32'(full | running), 0);

    // Random button activity against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) btn_start = ~btn_start;
      if ($urandom_range(0, 7) == 0) btn_lap = ~btn_lap;
      if ($urandom_range(0, 40) == 0) btn_clear = ~btn_clear;
      cycle();
    end
    btn_start = 0; btn_lap = 0; btn_clear = 0;
    step(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
